// File: rtl/spi_slave_shift_pkg.sv
// Shared SPI peripheral types: data width, synchronizer depth and slave FSM states.
package spi_slave_shift_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_SYNC_W     = 2;

    typedef logic [SPI_DATA_WIDTH-1:0] spi_data_t;

    typedef enum logic [1:0] {
        SLV_IDLE,
        SLV_LOAD,
        SLV_SHIFT,
        SLV_DONE
    } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// SYNC_W-flop synchronizer for one async input with 1-pclk rise/fall pulses.
// Latency SYNC_W pclk to q_o and to the edge pulses; no backpressure.
module spi_sync_edge
    import spi_slave_shift_pkg::*;
#(
    parameter int SYNC_W = SPI_SYNC_W
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_W-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_W-2:0], d_i};
            prev_q <= sync_q[SYNC_W-1];
        end
    end

    assign q_o    = sync_q[SYNC_W-1];
    assign rise_o = sync_q[SYNC_W-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_W-1] & prev_q;

endmodule

// File: rtl/spi_slave_shift.sv
// SPI slave shift engine: miso moves SYNC_W+1 pclk after a raw shift edge, rx_valid SYNC_W+2 after the last sample.
// A full rx word is dropped (overrun) while rx_valid is unacknowledged; an empty tx holding register sends zeros (underrun).
module spi_slave_shift
    import spi_slave_shift_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_WIDTH,
    parameter int SYNC_W = SPI_SYNC_W
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              sclk_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              clr_flags,
    output logic              overrun,
    output logic              underrun,
    output logic              abort,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_W(SYNC_W)) u_sync_sclk (
        .pclk(pclk), .preset_n(preset_n), .d_i(sclk_i),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_W(SYNC_W)) u_sync_ss (
        .pclk(pclk), .preset_n(preset_n), .d_i(ss_i),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall_unused)
    );
    spi_sync_edge #(.SYNC_W(SYNC_W)) u_sync_mosi (
        .pclk(pclk), .preset_n(preset_n), .d_i(mosi_i),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_slv_state_e    state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic              hold_vld_q, hold_vld_d, rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d, underrun_q, underrun_d;
    logic              abort_q, abort_d, miso_q, miso_d, cpol_q, cpol_d, cpha_q, cpha_d;

    logic              lead_edge, trail_edge, sample_edge, shift_edge, tx_hs;
    logic [DATA_W-1:0] load_word;

    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    // LOAD empties the holding register this cycle, so it can accept a new word at once.
    assign tx_ready    = !hold_vld_q || (state_q == SLV_LOAD);
    assign tx_hs       = tx_valid && tx_ready;
    assign load_word   = hold_vld_q ? hold_q : '0;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        abort_d    = 1'b0;
        miso_d     = miso_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;

        if (clr_flags) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (tx_hs) begin
            hold_d     = tx_data;
            hold_vld_d = 1'b1;
        end

        unique case (state_q)
            SLV_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (ss_rise) state_d = SLV_LOAD;
            end
            SLV_LOAD: begin
                cpol_d     = cpol;
                cpha_d     = cpha;
                bit_cnt_d  = '0;
                hold_vld_d = tx_hs;
                if (!hold_vld_q) underrun_d = 1'b1;
                if (cpha) begin
                    tx_sr_d = load_word;
                end else begin
                    miso_d  = load_word[DATA_W-1];
                    tx_sr_d = load_word << 1;
                end
                state_d = SLV_SHIFT;
            end
            SLV_SHIFT: begin
                if (!ss_s) begin
                    abort_d = (bit_cnt_q != '0);
                    state_d = SLV_IDLE;
                end else if (sample_edge) begin
                    rx_sr_d   = {rx_sr_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) state_d = SLV_DONE;
                // In cpha=0 the trailing edge after the last sample belongs to the finished word.
                end else if (shift_edge && (cpha_q || bit_cnt_q != '0)) begin
                    miso_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end
            end
            SLV_DONE: begin
                bit_cnt_d = '0;
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = ss_s ? SLV_LOAD : SLV_IDLE;
            end
            default: state_d = SLV_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= SLV_IDLE;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            miso_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
            miso_q     <= miso_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
        end
    end

    assign miso_o   = ss_s & miso_q;
    assign miso_oe  = ss_s;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;
    assign abort    = abort_q;
    assign busy     = (state_q != SLV_IDLE);

endmodule

// File: tb/tb_spi_slave_shift.sv
// Bench for spi_slave_shift: an SPI master model at f_pclk/8 with scoreboard queues of expected words.
module tb_spi_slave_shift;

    logic       pclk, preset_n;
    logic       sclk_i, ss_i, mosi_i, miso_o, miso_oe, cpol, cpha;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, clr_flags;
    logic       overrun, underrun, abort, busy;

    int n_checks  = 0;
    int n_pass    = 0;
    int unstable  = 0;
    int abort_cnt = 0;

    logic [7:0] miso_exp_q[$];
    logic [7:0] rx_exp_q[$];

    spi_slave_shift #(.DATA_W(8), .SYNC_W(2)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe(miso_oe),
        .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .clr_flags(clr_flags), .overrun(overrun), .underrun(underrun),
        .abort(abort), .busy(busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) if (abort === 1'b1) abort_cnt++;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic preload(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        clk_wait(1);
        tx_valid = 1'b0;
    endtask

    task automatic consume_rx();
        rx_ready = 1'b1;
        clk_wait(1);
        rx_ready = 1'b0;
        clk_wait(1);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        clk_wait(1);
        clr_flags = 1'b0;
        clk_wait(1);
    endtask

    task automatic wait_rx_valid();
        for (int k = 0; k < 64 && rx_valid !== 1'b1; k++) clk_wait(1);
    endtask

    task automatic ss_on(input logic pol, input logic pha);
        cpol   = pol;
        cpha   = pha;
        sclk_i = pol;
        clk_wait(4);
        ss_i = 1'b1;
        clk_wait(8);
    endtask

    // Sends the top nbits of d MSB first; 'last' releases ss one pclk after the final sample edge.
    task automatic spi_word(input logic [7:0] d, input int nbits, input bit last,
                            output logic [7:0] rd);
        logic m0;
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_i = d[7-i];
                clk_wait(4);
                sclk_i = ~cpol;
            end else begin
                sclk_i = ~cpol;
                mosi_i = d[7-i];
                clk_wait(4);
                sclk_i = cpol;
            end
            m0 = miso_o;
            rd = {rd[6:0], m0};
            clk_wait(1);
            if (last && i == nbits - 1) ss_i = 1'b0;
            clk_wait(1);
            if (miso_o !== m0) unstable++;
            clk_wait(2);
            if (!cpha) sclk_i = cpol;
        end
        if (last) clk_wait(8);
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        clk_wait(2);
        n_checks++;
        if ({miso_o, miso_oe, tx_ready, rx_valid, overrun, underrun, abort, busy} !== 8'b0010_0000)
            $display("FAIL reset_ctrl: got %b required 00100000",
                     {miso_o, miso_oe, tx_ready, rx_valid, overrun, underrun, abort, busy});
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", rx_data);
        else n_pass++;
        preset_n = 1'b1;
        clk_wait(4);
        n_checks++;
        if ({tx_ready, busy} !== 2'b10) $display("FAIL post_reset_idle: got %b required 10", {tx_ready, busy});
        else n_pass++;
    endtask

    task automatic test_mode(input logic pol, input logic pha, input string nm);
        logic [7:0] rd, exp;
        int base_unstable;
        preload(8'hA5);
        miso_exp_q.push_back(8'hA5);
        rx_exp_q.push_back(8'h3C);
        n_checks++;
        if (tx_ready !== 1'b0) $display("FAIL %s_tx_full: tx_ready got %b required 0", nm, tx_ready);
        else n_pass++;
        base_unstable = unstable;
        ss_on(pol, pha);
        spi_word(8'h3C, 8, 1'b1, rd);
        exp = miso_exp_q.pop_front();
        n_checks++;
        if (rd !== exp) $display("FAIL %s_miso_word: got %h required %h", nm, rd, exp);
        else n_pass++;
        wait_rx_valid();
        exp = rx_exp_q.pop_front();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp)
            $display("FAIL %s_rx: valid %b data %h required valid 1 data %h", nm, rx_valid, rx_data, exp);
        else n_pass++;
        n_checks++;
        if ({overrun, underrun, tx_ready} !== 3'b001)
            $display("FAIL %s_flags: ovr/und/tx_ready got %b required 001", nm, {overrun, underrun, tx_ready});
        else n_pass++;
        if (pha) begin
            n_checks++;
            if (unstable != base_unstable)
                $display("FAIL %s_miso_stable: %0d unstable samples required 0", nm, unstable - base_unstable);
            else n_pass++;
        end
        consume_rx();
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL %s_rx_ack: rx_valid got %b required 0", nm, rx_valid);
        else n_pass++;
    endtask

    task automatic test_underrun();
        logic [7:0] rd, exp;
        miso_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'h96);
        ss_on(1'b0, 1'b0);
        spi_word(8'h96, 8, 1'b1, rd);
        exp = miso_exp_q.pop_front();
        n_checks++;
        if (rd !== exp) $display("FAIL underrun_miso: got %h required %h", rd, exp);
        else n_pass++;
        wait_rx_valid();
        exp = rx_exp_q.pop_front();
        n_checks++;
        if (rx_data !== exp || underrun !== 1'b1)
            $display("FAIL underrun_flag: rx %h underrun %b required rx %h underrun 1", rx_data, underrun, exp);
        else n_pass++;
        consume_rx();
        pulse_clr();
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL underrun_clear: got %b required 0", underrun);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, exp;
        rx_ready = 1'b0;
        rx_exp_q.push_back(8'h11);
        ss_on(1'b0, 1'b0);
        spi_word(8'h11, 8, 1'b0, rd);
        spi_word(8'h22, 8, 1'b1, rd);
        wait_rx_valid();
        exp = rx_exp_q.pop_front();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp || overrun !== 1'b1)
            $display("FAIL b2b_overrun: valid %b data %h ovr %b required 1 %h 1", rx_valid, rx_data, overrun, exp);
        else n_pass++;
        consume_rx();
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL b2b_rx_ack: rx_valid got %b required 0", rx_valid);
        else n_pass++;
        pulse_clr();
        n_checks++;
        if ({overrun, underrun} !== 2'b00) $display("FAIL b2b_clear: got %b required 00", {overrun, underrun});
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] rd, exp;
        int base;
        base = abort_cnt;
        ss_on(1'b0, 1'b0);
        spi_word(8'hFF, 3, 1'b1, rd);
        n_checks++;
        if (abort_cnt - base != 1 || rx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_pulse: aborts %0d rx_valid %b busy %b required 1 0 0",
                     abort_cnt - base, rx_valid, busy);
        else n_pass++;
        pulse_clr();
        preload(8'h24);
        miso_exp_q.push_back(8'h24);
        rx_exp_q.push_back(8'h5A);
        ss_on(1'b0, 1'b0);
        spi_word(8'h5A, 8, 1'b1, rd);
        exp = miso_exp_q.pop_front();
        n_checks++;
        if (rd !== exp) $display("FAIL abort_next_miso: got %h required %h", rd, exp);
        else n_pass++;
        wait_rx_valid();
        exp = rx_exp_q.pop_front();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp || {overrun, underrun} !== 2'b00)
            $display("FAIL abort_next_rx: valid %b data %h flags %b required 1 %h 00",
                     rx_valid, rx_data, {overrun, underrun}, exp);
        else n_pass++;
        consume_rx();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd, exp;
        int base;
        preload(8'hC3);
        ss_on(1'b0, 1'b0);
        spi_word(8'hF0, 4, 1'b0, rd);
        preset_n = 1'b0;
        #1;
        n_checks++;
        if ({miso_o, miso_oe, tx_ready, rx_valid, overrun, underrun, abort, busy} !== 8'b0010_0000 ||
            rx_data !== 8'h00)
            $display("FAIL reset_mid: ctrl %b rx %h required 00100000 00",
                     {miso_o, miso_oe, tx_ready, rx_valid, overrun, underrun, abort, busy}, rx_data);
        else n_pass++;
        ss_i   = 1'b0;
        sclk_i = 1'b0;
        mosi_i = 1'b0;
        clk_wait(3);
        preset_n = 1'b1;
        clk_wait(4);
        base = abort_cnt;
        preload(8'h81);
        miso_exp_q.push_back(8'h81);
        rx_exp_q.push_back(8'hE7);
        ss_on(1'b0, 1'b0);
        spi_word(8'hE7, 8, 1'b1, rd);
        exp = miso_exp_q.pop_front();
        n_checks++;
        if (rd !== exp) $display("FAIL reset_mid_next_miso: got %h required %h", rd, exp);
        else n_pass++;
        wait_rx_valid();
        exp = rx_exp_q.pop_front();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp || {overrun, underrun} !== 2'b00 || abort_cnt != base)
            $display("FAIL reset_mid_next_rx: valid %b data %h flags %b aborts %0d required 1 %h 00 0",
                     rx_valid, rx_data, {overrun, underrun}, abort_cnt - base, exp);
        else n_pass++;
        consume_rx();
    endtask

    initial begin
        preset_n  = 1'b0;
        sclk_i    = 1'b0;
        ss_i      = 1'b0;
        mosi_i    = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        clr_flags = 1'b0;

        test_reset();
        test_mode(1'b0, 1'b0, "mode0");
        test_mode(1'b1, 1'b1, "mode3");
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
